// File: rtl/shifter_share_arb.sv
// Round-robin arbiter sharing one registered barrel shifter among NREQ requesters.
// Result is returned tagged with the winning requester index under valid/ready.
module shifter_share_arb #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int SHW   = 4,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic [NREQ*SHW-1:0]   req_shift,
    input  logic [NREQ-1:0]       req_op,
    input  logic [NREQ-1:0]       req_val,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_data,
    output logic [IDW-1:0]        rsp_id,
    output logic                  busy
);

    logic [IDW-1:0]   r_ptr;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_data;
    logic [IDW-1:0]   r_rsp_id;

    logic             w_slot_free;
    logic             w_found;
    logic             w_accept;
    logic [IDW-1:0]   w_gnt;
    logic [IDW:0]     w_idx;
    logic [IDW-1:0]   w_ptr_nxt;
    logic [WIDTH-1:0] w_in;
    logic [SHW-1:0]   w_sh;
    logic             w_op;
    logic             w_fill;
    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_res;

    assign w_slot_free = !r_rsp_valid | rsp_ready;

    // Cyclic search starting at the pointer; first valid requester wins.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_idx = {1'b0, r_ptr} + (IDW+1)'(i);
            if (w_idx >= (IDW+1)'(NREQ))
                w_idx = w_idx - (IDW+1)'(NREQ);
            if (!w_found && req_valid[w_idx[IDW-1:0]]) begin
                w_found = 1'b1;
                w_gnt   = w_idx[IDW-1:0];
            end
        end
    end

    assign w_accept = w_slot_free & w_found;

    always_comb begin
        req_ready = '0;
        if (w_accept)
            req_ready[w_gnt] = 1'b1;
    end

    always_comb begin
        w_in   = req_data[int'(w_gnt)*WIDTH +: WIDTH];
        w_sh   = req_shift[int'(w_gnt)*SHW +: SHW];
        w_op   = req_op[w_gnt];
        w_fill = req_val[w_gnt];
    end

    // Mask of surviving bit positions; shifts of WIDTH or more clear it entirely.
    always_comb begin
        if (w_op) begin
            w_mask = {WIDTH{1'b1}} << w_sh;
            w_res  = (w_in << w_sh) | (~w_mask & {WIDTH{w_fill}});
        end else begin
            w_mask = {WIDTH{1'b1}} >> w_sh;
            w_res  = (w_in >> w_sh) | (~w_mask & {WIDTH{w_fill}});
        end
    end

    assign w_ptr_nxt = (w_gnt == IDW'(NREQ-1)) ? '0 : w_gnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_id    <= '0;
        end else if (w_accept) begin
            r_ptr       <= w_ptr_nxt;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_res;
            r_rsp_id    <= w_gnt;
        end else if (r_rsp_valid && rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;
    assign busy      = r_rsp_valid | (|req_valid);

endmodule

// File: tb/tb_shifter_share_arb.sv
// Directed bench for shifter_share_arb with a reference model
// and an expected-result queue checked when results are consumed.
module tb_shifter_share_arb;

    localparam int N = 4;
    localparam int W = 8;
    localparam int S = 4;
    localparam int I = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_data;
    logic [N*S-1:0] req_shift;
    logic [N-1:0]   req_op;
    logic [N-1:0]   req_val;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_data;
    logic [I-1:0]   rsp_id;
    logic           busy;

    logic [W-1:0] d [N];
    logic [S-1:0] s [N];
    logic         o [N];
    logic         v [N];

    int tests = 0;
    int fails = 0;
    logic         m_valid;
    int           m_ptr;
    logic [I+W-1:0] q[$];
    logic [W-1:0] hold_d;
    logic [I-1:0] hold_id;

    always #5 clk = ~clk;

    always_comb begin
        req_data  = '0;
        req_shift = '0;
        req_op    = '0;
        req_val   = '0;
        for (int k = 0; k < N; k++) begin
            req_data[k*W +: W]  = d[k];
            req_shift[k*S +: S] = s[k];
            req_op[k]           = o[k];
            req_val[k]          = v[k];
        end
    end

    shifter_share_arb #(.NREQ(N), .WIDTH(W), .SHW(S), .IDW(I)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_shift(req_shift),
        .req_op(req_op), .req_val(req_val),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
    );

    function automatic logic [W-1:0] shf(logic [W-1:0] x, logic [S-1:0] sh,
                                         logic left, logic fill);
        logic [W-1:0] r;
        int si;
        si = int'(sh);
        for (int b = 0; b < W; b++) begin
            if (left) r[b] = (b >= si) ? x[b-si] : fill;
            else      r[b] = (b + si < W) ? x[b+si] : fill;
        end
        return r;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock with model-based checking of grant, slot and returned result.
    task automatic cyc();
        logic [N-1:0] er;
        int k;
        logic [I+W-1:0] e;
        #1;
        er = '0;
        k = -1;
        if (!m_valid || rsp_ready) begin
            for (int i = 0; i < N; i++)
                if (k < 0 && req_valid[(m_ptr + i) % N]) k = (m_ptr + i) % N;
            if (k >= 0) er[k] = 1'b1;
        end
        chk("ready", 32'(req_ready), 32'(er));
        chk("valid", 32'(rsp_valid), 32'(m_valid));
        chk("busy", 32'(busy), 32'(m_valid | (|req_valid)));
        if (m_valid && rsp_ready) begin
            if (q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
            else begin
                e = q.pop_front();
                chk("sb_result", 32'({rsp_id, rsp_data}), 32'(e));
            end
        end
        if (k >= 0) begin
            q.push_back({I'(k), shf(d[k], s[k], o[k], v[k])});
            m_valid = 1'b1;
            m_ptr = (k + 1) % N;
        end else if (m_valid && rsp_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(int k, logic [W-1:0] dd, logic [S-1:0] ss,
                           logic oo, logic vv);
        d[k] = dd; s[k] = ss; o[k] = oo; v[k] = vv;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_valid = 1'b0;
        m_ptr = 0;
        q.delete();
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        for (int k = 0; k < N; k++) set_req(k, '0, '0, 1'b0, 1'b0);
        m_valid = 1'b0;
        m_ptr = 0;
        @(posedge clk);
        do_reset();
        #1;
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_data", 32'(rsp_data), 32'd0);
        chk("rst_id", 32'(rsp_id), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // single left shift from requester 2
        set_req(2, 8'hB4, 4'd3, 1'b1, 1'b0);
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        #1;
        chk("t1_ready", 32'(req_ready), 32'b0100);
        cyc();
        req_valid = '0;
        chk("t1_valid", 32'(rsp_valid), 32'd1);
        chk("t1_data", 32'(rsp_data), 32'hA0);
        chk("t1_id", 32'(rsp_id), 32'd2);
        cyc();
        chk("t1_drop", 32'(rsp_valid), 32'd0);

        // right shifts with fill
        set_req(0, 8'h81, 4'd2, 1'b0, 1'b1);
        req_valid = 4'b0001; cyc(); req_valid = '0;
        chk("t2_r2", 32'(rsp_data), 32'hE0);
        cyc();
        set_req(0, 8'h81, 4'd9, 1'b0, 1'b1);
        req_valid = 4'b0001; cyc(); req_valid = '0;
        chk("t2_r9", 32'(rsp_data), 32'hFF);
        cyc();
        set_req(0, 8'h81, 4'd0, 1'b0, 1'b1);
        req_valid = 4'b0001; cyc(); req_valid = '0;
        chk("t2_r0", 32'(rsp_data), 32'h81);
        chk("t2_hold_id", 32'(rsp_id), 32'd0);
        cyc();

        // round robin at full throughput
        do_reset();
        set_req(0, 8'h3C, 4'd1, 1'b1, 1'b1);
        set_req(1, 8'hA5, 4'd4, 1'b0, 1'b0);
        set_req(2, 8'h0F, 4'd7, 1'b1, 1'b0);
        set_req(3, 8'hF0, 4'd15, 1'b0, 1'b0);
        req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("rr_grant", 32'(req_ready), 32'(1 << (i % 4)));
            if (i > 0) begin
                chk("rr_valid", 32'(rsp_valid), 32'd1);
                chk("rr_id", 32'(rsp_id), 32'((i - 1) % 4));
            end
            cyc();
        end
        req_valid = '0;
        cyc();

        // backpressure: result from req 0 held while req 1 waits
        rsp_ready = 1'b0;
        set_req(0, 8'h5A, 4'd2, 1'b1, 1'b1);
        req_valid = 4'b0001;
        cyc();
        hold_d = 8'h6B;
        hold_id = 2'd0;
        set_req(1, 8'hC3, 4'd3, 1'b0, 1'b0);
        req_valid = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("bp_data", 32'(rsp_data), 32'(hold_d));
            chk("bp_id", 32'(rsp_id), 32'(hold_id));
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release", 32'(req_ready), 32'b0010);
        cyc();
        req_valid = '0;
        chk("bp_new_id", 32'(rsp_id), 32'd1);
        chk("bp_new_data", 32'(rsp_data), 32'h18);
        cyc();

        // pointer fairness and idle stability
        req_valid = 4'b1000; cyc();
        req_valid = 4'b1001;
        #1; chk("fair_0", 32'(req_ready), 32'b0001); cyc();
        #1; chk("fair_3", 32'(req_ready), 32'b1000); cyc();
        req_valid = 4'b0010; cyc();
        req_valid = '0;
        for (int i = 0; i < 10; i++) cyc();
        req_valid = 4'b1001;
        #1; chk("idle_ptr", 32'(req_ready), 32'b1000); cyc();
        req_valid = '0;
        cyc();

        // reset while a result is pending
        rsp_ready = 1'b0;
        req_valid = 4'b0100; cyc();
        req_valid = '0;
        do_reset();
        #1;
        chk("mr_valid", 32'(rsp_valid), 32'd0);
        chk("mr_data", 32'(rsp_data), 32'd0);
        chk("mr_id", 32'(rsp_id), 32'd0);
        chk("mr_ready", 32'(req_ready), 32'd0);
        req_valid = 4'b0101;
        #1; chk("mr_ptr", 32'(req_ready), 32'b0001);
        cyc();
        req_valid = '0;
        rsp_ready = 1'b1;
        cyc();
        cyc();
        chk("sb_drained", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
